// File: rtl/router_output_arbiter.sv
// Round-robin packet arbiter for one router output port; drives the payload mux select/enable.
// Optional grant watchdog: define ROUTER_ARB_TIMEOUT_EN to revoke grants held TIMEOUT_CYCLES cycles.
module router_output_arbiter #(
    parameter int NREQ           = 8,
    parameter int IDW            = 3,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic [NREQ-1:0] req,
    input  logic [NREQ-1:0] done,
    input  logic            fifo_full,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  gnt_id,
    output logic            gnt_vld,
    output logic            stall,
    output logic            timeout
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    state_t          state_r;
    logic [IDW-1:0]  ptr_r;
    logic [NREQ-1:0] gnt_r;
    logic [IDW-1:0]  gnt_id_r;
    logic            gnt_vld_r;
    logic            pick_vld_s;
    logic [IDW-1:0]  pick_id_s;
    logic            owner_end_s;

`ifdef ROUTER_ARB_TIMEOUT_EN
    localparam int HOLD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(TIMEOUT_CYCLES);
    logic [HOLD_W-1:0] hold_cnt_r;
    logic              timeout_r;
`endif

    // First set request at or after the pointer; the index wraps naturally in IDW bits.
    function automatic logic [IDW:0] rr_pick(input logic [NREQ-1:0] r, input logic [IDW-1:0] p);
        logic [IDW:0]   res;
        logic [IDW-1:0] idx;
        res = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            idx = p + IDW'(i);
            if (r[idx]) begin
                res = {1'b1, idx};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    // Winner candidate and owner-completion detection.
    always_comb begin
        {pick_vld_s, pick_id_s} = rr_pick(req, ptr_r);
        owner_end_s             = done[gnt_id_r] | ~req[gnt_id_r];
    end

    // Arbitration state machine with registered grant outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= ST_IDLE;
            ptr_r      <= '0;
            gnt_r      <= '0;
            gnt_id_r   <= '0;
            gnt_vld_r  <= 1'b0;
`ifdef ROUTER_ARB_TIMEOUT_EN
            hold_cnt_r <= '0;
            timeout_r  <= 1'b0;
`endif
        end else begin
`ifdef ROUTER_ARB_TIMEOUT_EN
            timeout_r <= 1'b0;
`endif
            case (state_r)
                ST_IDLE: begin
                    if (pick_vld_s && !fifo_full) begin
                        gnt_r      <= NREQ'(1) << pick_id_s;
                        gnt_id_r   <= pick_id_s;
                        gnt_vld_r  <= 1'b1;
                        state_r    <= ST_GRANT;
`ifdef ROUTER_ARB_TIMEOUT_EN
                        hold_cnt_r <= '0;
`endif
                    end
                end
                ST_GRANT: begin
                    // A dropped request is an abort and releases like a completed packet.
                    if (owner_end_s) begin
                        gnt_r     <= '0;
                        gnt_vld_r <= 1'b0;
                        ptr_r     <= gnt_id_r + IDW'(1);
                        state_r   <= ST_RELEASE;
                    end
`ifdef ROUTER_ARB_TIMEOUT_EN
                    else if (hold_cnt_r == HOLD_LAST) begin
                        gnt_r     <= '0;
                        gnt_vld_r <= 1'b0;
                        ptr_r     <= gnt_id_r + IDW'(1);
                        timeout_r <= 1'b1;
                        state_r   <= ST_RELEASE;
                    end else if (hold_cnt_r != HOLD_MAX) begin
                        hold_cnt_r <= hold_cnt_r + HOLD_W'(1);
                    end
`endif
                end
                ST_RELEASE: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r   <= ST_IDLE;
                    gnt_r     <= '0;
                    gnt_vld_r <= 1'b0;
                end
            endcase
        end
    end

    assign gnt     = gnt_r;
    assign gnt_id  = gnt_id_r;
    assign gnt_vld = gnt_vld_r;
    assign stall   = gnt_vld_r & fifo_full;
`ifdef ROUTER_ARB_TIMEOUT_EN
    assign timeout = timeout_r;
`else
    assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_router_output_arbiter.sv
// Self-checking bench for router_output_arbiter: vector table, directed corner cases, random run vs model.
module tb_router_output_arbiter;

    localparam int TO = 16;

    logic       clock;
    logic       reset_n;
    logic [7:0] req;
    logic [7:0] done;
    logic       fifo_full;
    logic [7:0] gnt;
    logic [2:0] gnt_id;
    logic       gnt_vld;
    logic       stall;
    logic       timeout;

    int total;
    int bad;

    // Reference model: current owner (-1 none), turnaround pending, next search start.
    int   m_owner;
    bit   m_turn;
    int   m_ptr;
    int   m_held;
    bit   m_to;

    typedef struct {
        logic [7:0] r;
        logic [7:0] d;
        logic       ff;
        logic [7:0] g;
        logic [2:0] id;
        logic       st;
    } vec_t;

    vec_t tbl[22];

    router_output_arbiter #(.NREQ(8), .IDW(3), .TIMEOUT_CYCLES(TO)) dut (
        .clock(clock), .reset_n(reset_n), .req(req), .done(done), .fifo_full(fifo_full),
        .gnt(gnt), .gnt_id(gnt_id), .gnt_vld(gnt_vld), .stall(stall), .timeout(timeout)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_turn  = 1'b0;
        m_ptr   = 0;
        m_held  = 0;
        m_to    = 1'b0;
    endtask

    task automatic model_step(input logic [7:0] r, input logic [7:0] d, input logic ff);
        m_to = 1'b0;
        if (m_owner >= 0) begin
            if (d[m_owner] || !r[m_owner]) begin
                m_ptr   = (m_owner + 1) % 8;
                m_owner = -1;
                m_turn  = 1'b1;
            end
`ifdef ROUTER_ARB_TIMEOUT_EN
            else if (m_held == TO - 1) begin
                m_ptr   = (m_owner + 1) % 8;
                m_owner = -1;
                m_turn  = 1'b1;
                m_to    = 1'b1;
            end
`endif
            else begin
                m_held++;
            end
        end else if (m_turn) begin
            m_turn = 1'b0;
        end else if (r != 8'h00 && !ff) begin
            for (int k = 0; k < 8; k++) begin
                if (m_owner < 0 && r[(m_ptr + k) % 8]) begin
                    m_owner = (m_ptr + k) % 8;
                    m_held  = 0;
                end
            end
        end
    endtask

    task automatic check_model();
        logic [7:0] eg;
        eg = (m_owner >= 0) ? (8'h01 << m_owner) : 8'h00;
        chk("model_gnt", gnt, eg);
        chk("model_vld", gnt_vld, (m_owner >= 0));
        if (m_owner >= 0) chk("model_id", gnt_id, m_owner);
        chk("model_timeout", timeout, m_to);
        chk("model_stall", stall, (m_owner >= 0) && fifo_full);
        chk("onehot", ($countones(gnt) <= 1), 1'b1);
    endtask

    task automatic cycle(input logic [7:0] r, input logic [7:0] d, input logic ff);
        req       = r;
        done      = d;
        fifo_full = ff;
        @(posedge clock);
        model_step(r, d, ff);
        #1;
        check_model();
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset_n = 1'b0;
        req = 8'h00; done = 8'h00; fifo_full = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        model_reset();
    endtask

    initial begin
        int g2;
        int tcnt;
        logic [7:0] rr;
        total = 0;
        bad   = 0;
        reset_n = 1'b1;
        req = 8'h00; done = 8'h00; fifo_full = 1'b0;
        model_reset();
        do_reset();
        #1;
        chk("reset_gnt", gnt, 8'h00);
        chk("reset_vld", gnt_vld, 1'b0);
        chk("reset_id", gnt_id, 3'd0);
        chk("reset_timeout", timeout, 1'b0);

        // Single request, hold, release turnaround, round-robin 0/7 wrap, stall, ignored done, abort.
        tbl[0]  = '{8'h01, 8'h00, 1'b0, 8'h01, 3'd0, 1'b0};
        tbl[1]  = '{8'h01, 8'h00, 1'b0, 8'h01, 3'd0, 1'b0};
        tbl[2]  = '{8'h01, 8'h00, 1'b0, 8'h01, 3'd0, 1'b0};
        tbl[3]  = '{8'h01, 8'h00, 1'b0, 8'h01, 3'd0, 1'b0};
        tbl[4]  = '{8'h01, 8'h00, 1'b0, 8'h01, 3'd0, 1'b0};
        tbl[5]  = '{8'h01, 8'h01, 1'b0, 8'h00, 3'd0, 1'b0};
        tbl[6]  = '{8'h01, 8'h00, 1'b0, 8'h00, 3'd0, 1'b0};
        tbl[7]  = '{8'h01, 8'h00, 1'b0, 8'h01, 3'd0, 1'b0};
        tbl[8]  = '{8'h81, 8'h01, 1'b0, 8'h00, 3'd0, 1'b0};
        tbl[9]  = '{8'h81, 8'h00, 1'b0, 8'h00, 3'd0, 1'b0};
        tbl[10] = '{8'h81, 8'h00, 1'b0, 8'h80, 3'd7, 1'b0};
        tbl[11] = '{8'h81, 8'h80, 1'b0, 8'h00, 3'd0, 1'b0};
        tbl[12] = '{8'h81, 8'h00, 1'b0, 8'h00, 3'd0, 1'b0};
        tbl[13] = '{8'h81, 8'h00, 1'b0, 8'h01, 3'd0, 1'b0};
        tbl[14] = '{8'h81, 8'h00, 1'b1, 8'h01, 3'd0, 1'b1};
        tbl[15] = '{8'h81, 8'h20, 1'b0, 8'h01, 3'd0, 1'b0};
        tbl[16] = '{8'h80, 8'h00, 1'b0, 8'h00, 3'd0, 1'b0};
        tbl[17] = '{8'h80, 8'h00, 1'b0, 8'h00, 3'd0, 1'b0};
        tbl[18] = '{8'h80, 8'h00, 1'b0, 8'h80, 3'd7, 1'b0};
        tbl[19] = '{8'h00, 8'h00, 1'b0, 8'h00, 3'd0, 1'b0};
        tbl[20] = '{8'h00, 8'h00, 1'b0, 8'h00, 3'd0, 1'b0};
        tbl[21] = '{8'h00, 8'h00, 1'b0, 8'h00, 3'd0, 1'b0};
        for (int i = 0; i < 22; i++) begin
            cycle(tbl[i].r, tbl[i].d, tbl[i].ff);
            chk($sformatf("tbl%0d_gnt", i), gnt, tbl[i].g);
            chk($sformatf("tbl%0d_vld", i), gnt_vld, |tbl[i].g);
            if (tbl[i].g != 8'h00) chk($sformatf("tbl%0d_id", i), gnt_id, tbl[i].id);
            chk($sformatf("tbl%0d_stall", i), stall, tbl[i].st);
        end

        // Asynchronous reset in the middle of a grant, away from any clock edge.
        cycle(8'h20, 8'h00, 1'b0);
        chk("pre_rst_gnt", gnt, 8'h20);
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        chk("async_rst_gnt", gnt, 8'h00);
        chk("async_rst_vld", gnt_vld, 1'b0);
        chk("async_rst_id", gnt_id, 3'd0);
        @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        model_reset();
        cycle(8'hFF, 8'h00, 1'b0);
        chk("post_rst_first", gnt, 8'h01);

        // Backpressure blocks new grants but never revokes one.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            cycle(8'h04, 8'h00, 1'b1);
            chk("bp_blocked", gnt, 8'h00);
        end
        cycle(8'h04, 8'h00, 1'b0);
        chk("bp_grant", gnt, 8'h04);
        req = 8'h04; fifo_full = 1'b1;
        #1;
        chk("bp_stall_same_cycle", stall, 1'b1);
        cycle(8'h04, 8'h00, 1'b1);
        chk("bp_held", gnt, 8'h04);

        // Abort by owner 3 moves the pointer to 4; a non-owner done is ignored.
        do_reset();
        cycle(8'h08, 8'h00, 1'b0);
        chk("abort_own3", gnt, 8'h08);
        cycle(8'h10, 8'h00, 1'b0);
        chk("abort_rel", gnt, 8'h00);
        cycle(8'h1F, 8'h00, 1'b0);
        cycle(8'h1F, 8'h00, 1'b0);
        chk("abort_ptr4", gnt, 8'h10);
        cycle(8'h1F, 8'h20, 1'b0);
        chk("foreign_done", gnt, 8'h10);
        cycle(8'h1F, 8'h10, 1'b0);

        // Grant watchdog: revoked after TO cycles with a one-cycle pulse, or held indefinitely.
        do_reset();
        g2 = 0;
        tcnt = 0;
`ifdef ROUTER_ARB_TIMEOUT_EN
        for (int i = 0; i < 20; i++) begin
            cycle(8'h0A, 8'h00, 1'b0);
            if (gnt == 8'h02) g2++;
            if (timeout) tcnt++;
        end
        chk("to_hold_cycles", g2, TO);
        chk("to_pulses", tcnt, 1);
        chk("to_next_owner", gnt, 8'h08);
`else
        for (int i = 0; i < 120; i++) begin
            cycle(8'h0A, 8'h00, 1'b0);
            if (gnt == 8'h02) g2++;
            if (timeout) tcnt++;
        end
        chk("noto_hold_cycles", g2, 120);
        chk("noto_pulses", tcnt, 0);
`endif

        // Random traffic against the model.
        do_reset();
        rr = 8'h00;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(7) == 0) rr = 8'($urandom);
            cycle(rr, ($urandom_range(3) == 0) ? 8'($urandom) : 8'h00, ($urandom_range(4) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
